// File: rtl/nand_phy_dq_rdcal.sv
// rtl/nand_phy_dq_rdcal.sv - DQ byte-lane read-capture IDELAY calibration; optional debug taps via NAND_DQ_RDCAL_DBG_EN
module nand_phy_dq_rdcal #(
  parameter int                  DQ_WIDTH   = 8,
  parameter int                  TAP_MAX    = 31,
  parameter logic [DQ_WIDTH-1:0] PAT_RISE   = 8'hA5,
  parameter logic [DQ_WIDTH-1:0] PAT_FALL   = 8'h5A,
  parameter int                  SETTLE_CYC = 8,
  parameter int                  SAMPLE_CYC = 16,
  parameter int                  MIN_WIN    = 4,
  localparam int                 TW         = $clog2(TAP_MAX + 1)
) (
  input  logic                clk90,
  input  logic                rst90_n,
  input  logic                cal_start,
  input  logic [DQ_WIDTH-1:0] rd_data_rise,
  input  logic [DQ_WIDTH-1:0] rd_data_fall,
  output logic                dlyinc,
  output logic [DQ_WIDTH-1:0] dlyce,
  output logic                dlyrst,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_err,
  output logic [DQ_WIDTH-1:0] lane_err
`ifdef NAND_DQ_RDCAL_DBG_EN
  ,
  output logic [DQ_WIDTH*3*TW-1:0] dbg_win,
  output logic [TW-1:0]            dbg_tap
`endif
);

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_TAPS,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_STEP,
    S_CALC,
    S_CTR_RST,
    S_CTR_INC,
    S_DONE
  } state_t;

  state_t              state;
  logic [TW-1:0]       tap;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       k;
  logic [DQ_WIDTH-1:0] pass_acc;
  logic [DQ_WIDTH-1:0] in_win;
  logic [DQ_WIDTH-1:0] locked;
  logic [DQ_WIDTH-1:0] lane_bad;
  logic [TW-1:0]       win_start [DQ_WIDTH];
  logic [TW-1:0]       win_end   [DQ_WIDTH];
  logic [TW-1:0]       centre    [DQ_WIDTH];

  logic [DQ_WIDTH-1:0] lane_ok;
  logic [TW:0]         calc_sum    [DQ_WIDTH];
  logic [TW:0]         calc_span   [DQ_WIDTH];
  logic [TW-1:0]       calc_centre [DQ_WIDTH];
  logic [DQ_WIDTH-1:0] calc_bad;
  logic [TW-1:0]       max_centre;

  // a lane passes a cycle only when both edges carry its training bit
  assign lane_ok = ~((rd_data_rise ^ PAT_RISE) | (rd_data_fall ^ PAT_FALL));

  // window width and floor-centre per lane; extra bit keeps start+end from wrapping
  always_comb begin
    calc_sum    = '{default: '0};
    calc_span   = '{default: '0};
    calc_centre = '{default: '0};
    calc_bad    = '0;
    for (int i = 0; i < DQ_WIDTH; i++) begin
      calc_sum[i]    = {1'b0, win_end[i]} + {1'b0, win_start[i]};
      calc_span[i]   = {1'b0, win_end[i]} - {1'b0, win_start[i]} + (TW+1)'(1);
      calc_bad[i]    = !in_win[i] || (calc_span[i] < (TW+1)'(MIN_WIN));
      calc_centre[i] = calc_bad[i] ? '0 : calc_sum[i][TW:1];
    end
  end

  // largest centre sets how long the re-load stepping phase runs
  always_comb begin
    max_centre = '0;
    for (int i = 0; i < DQ_WIDTH; i++) begin
      if (centre[i] > max_centre) max_centre = centre[i];
    end
  end

  // calibration sequencer; outputs are registered and set on entry to the state that owns them
  always_ff @(posedge clk90) begin
    if (!rst90_n) begin
      state    <= S_IDLE;
      dlyinc   <= 1'b0;
      dlyce    <= '0;
      dlyrst   <= 1'b0;
      cal_busy <= 1'b0;
      cal_done <= 1'b0;
      cal_err  <= 1'b0;
      lane_err <= '0;
      tap      <= '0;
      cnt      <= '0;
      k        <= '0;
      pass_acc <= '0;
      in_win   <= '0;
      locked   <= '0;
      lane_bad <= '0;
      for (int i = 0; i < DQ_WIDTH; i++) begin
        win_start[i] <= '0;
        win_end[i]   <= '0;
        centre[i]    <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (cal_start) begin
            state    <= S_RST_TAPS;
            dlyrst   <= 1'b1;
            cal_busy <= 1'b1;
            cal_done <= 1'b0;
            cal_err  <= 1'b0;
            lane_err <= '0;
            tap      <= '0;
            in_win   <= '0;
            locked   <= '0;
          end
        end
        S_RST_TAPS: begin
          dlyrst <= 1'b0;
          cnt    <= '0;
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE_CYC - 1)) begin
            cnt      <= '0;
            pass_acc <= '1;
            state    <= S_SAMPLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SAMPLE: begin
          pass_acc <= pass_acc & lane_ok;
          if (cnt == CW'(SAMPLE_CYC - 1)) begin
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          for (int i = 0; i < DQ_WIDTH; i++) begin
            if (!locked[i]) begin
              if (pass_acc[i]) begin
                if (!in_win[i]) begin
                  win_start[i] <= tap;
                  in_win[i]    <= 1'b1;
                end
                win_end[i] <= tap;
              end else if (in_win[i]) begin
                locked[i] <= 1'b1;
              end
            end
          end
          if (tap == TW'(TAP_MAX)) begin
            state <= S_CALC;
          end else begin
            state  <= S_STEP;
            dlyinc <= 1'b1;
            dlyce  <= '1;
          end
        end
        S_STEP: begin
          dlyinc <= 1'b0;
          dlyce  <= '0;
          tap    <= tap + TW'(1);
          cnt    <= '0;
          state  <= S_SETTLE;
        end
        S_CALC: begin
          for (int i = 0; i < DQ_WIDTH; i++) centre[i] <= calc_centre[i];
          lane_bad <= calc_bad;
          dlyrst   <= 1'b1;
          state    <= S_CTR_RST;
        end
        S_CTR_RST: begin
          dlyrst <= 1'b0;
          if (max_centre == '0) begin
            cal_done <= 1'b1;
            cal_busy <= 1'b0;
            cal_err  <= |lane_bad;
            lane_err <= lane_bad;
            state    <= S_DONE;
          end else begin
            dlyinc <= 1'b1;
            for (int i = 0; i < DQ_WIDTH; i++) dlyce[i] <= (centre[i] != '0);
            k     <= TW'(1);
            state <= S_CTR_INC;
          end
        end
        S_CTR_INC: begin
          if (k == max_centre) begin
            dlyinc   <= 1'b0;
            dlyce    <= '0;
            cal_done <= 1'b1;
            cal_busy <= 1'b0;
            cal_err  <= |lane_bad;
            lane_err <= lane_bad;
            state    <= S_DONE;
          end else begin
            for (int i = 0; i < DQ_WIDTH; i++) dlyce[i] <= (k < centre[i]);
            k <= k + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NAND_DQ_RDCAL_DBG_EN
  // debug mirror of the live sweep tap and per-lane {centre,end,start}
  always_ff @(posedge clk90) begin
    if (!rst90_n) begin
      dbg_win <= '0;
      dbg_tap <= '0;
    end else begin
      dbg_tap <= tap;
      for (int i = 0; i < DQ_WIDTH; i++) begin
        dbg_win[i*3*TW +: 3*TW] <= {centre[i], win_end[i], win_start[i]};
      end
    end
  end
`endif

endmodule
